// File: rtl/noc_alloc_pkg.sv
// Shared definitions for the NoC switch allocator: the flit-type field width,
// the flit type encodings and the arbitration policy selectors.
package noc_alloc_pkg;

  localparam int FTYPE_W = 2;

  typedef enum logic [1:0] {
    ENC_HEAD = 2'd0,
    ENC_PAYL = 2'd1,
    ENC_TAIL = 2'd2,
    ENC_SING = 2'd3
  } ftype_e;

  localparam int POL_RR    = 0;
  localparam int POL_FIXED = 1;

endpackage

// File: rtl/noc_rr_arbiter.sv
// One-hot arbiter for the switch allocator.
//  req   in   N  requesting inputs
//  prio  in   N  one-hot round-robin pointer (ignored for fixed priority)
//  grant out  N  one-hot grant, zero when nothing requests
// Round-robin picks the first requester at or after prio, wrapping around.
// Fixed priority picks the lowest-index requester.
module noc_rr_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int N      = 3,
  parameter int POLICY = POL_RR
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] grant
);

  generate
    if (POLICY == POL_FIXED) begin : g_fixed
      logic unused_prio_s;
      assign unused_prio_s = ^prio;
      // Isolate the lowest set request bit.
      assign grant = req & (~req + N'(1));
    end else begin : g_rr
      logic [2*N-1:0] dbl_req_s;
      logic [2*N-1:0] dbl_gnt_s;
      // Subtracting the pointer from the doubled request vector clears the
      // first requester at or above the pointer; folding the halves handles
      // the wrap-around.
      assign dbl_req_s = {req, req};
      assign dbl_gnt_s = dbl_req_s & ~(dbl_req_s - {{N{1'b0}}, prio});
      assign grant     = dbl_gnt_s[N-1:0] | dbl_gnt_s[2*N-1:N];
    end
  endgenerate

endmodule

// File: rtl/noc_switch_allocator_param.sv
// Per-output-port switch allocator (one instance per output port).
//  clk           in   1              clock
//  rst           in   1              synchronous reset, active-high
//  which_port    in   PORT_ID_W      ID of the output port served here
//  flit_in       in   NUM_IN*FLIT_W  input flits, input i at [i*FLIT_W +: FLIT_W]
//  valid_in      in   NUM_IN         per-input flit valid
//  busy_in       in   1              downstream buffer cannot accept
//  select        out  NUM_IN         one-hot (or zero) crossbar select
//  valid_out     out  1              a flit is presented on this output
//  nack_out      out  NUM_IN         input wanted this port but was not accepted
//  shift_ctl     out  1              head/single granted; trim one route field
//  hold_timeout  out  1              one-cycle pulse when the watchdog drops a lock
// Heads and singles addressed to this port compete when no packet holds the
// output; a granted head locks the output to its input until its tail is
// accepted. With HOLD_MAX>0 a lock whose owner stays silent for HOLD_MAX
// cycles is dropped.
module noc_switch_allocator_param
  import noc_alloc_pkg::*;
#(
  parameter int NUM_IN    = 3,
  parameter int FLIT_W    = 80,
  parameter int PORT_ID_W = 3,
  parameter int POLICY    = POL_RR,
  parameter int HOLD_MAX  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORT_ID_W-1:0]     which_port,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  input  logic [NUM_IN-1:0]        valid_in,
  input  logic                     busy_in,
  output logic [NUM_IN-1:0]        select,
  output logic                     valid_out,
  output logic [NUM_IN-1:0]        nack_out,
  output logic                     shift_ctl,
  output logic                     hold_timeout
);

  localparam int                CNT_W     = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : {CNT_W{1'b0}};
  localparam logic              WD_EN     = (HOLD_MAX > 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_IN-1:0] PRIO_RST  = NUM_IN'(1);

  logic [NUM_IN-1:0] is_head_s, is_tail_s, is_sing_s, request_s;
  logic [NUM_IN-1:0] grant_s, want_s, accept_s, lock_next_s;
  logic [NUM_IN-1:0] prio_rot_s, prio_next_s;
  logic [NUM_IN-1:0] lock_r, prio_r;
  logic [CNT_W-1:0]  hold_cnt_r, hold_cnt_next_s;
  logic              hold_timeout_r;
  logic              avail_s, owner_acc_s, idle_s, fire_s;
  logic              unused_flit_s;

  // Payload bits beyond the type/destination fields are not inspected here.
  assign unused_flit_s = ^flit_in;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_dec
      logic [FTYPE_W-1:0]   ftype_s;
      logic [PORT_ID_W-1:0] dest_s;
      assign ftype_s       = flit_in[gi*FLIT_W +: FTYPE_W];
      assign dest_s        = flit_in[gi*FLIT_W+FTYPE_W +: PORT_ID_W];
      assign is_head_s[gi] = (ftype_s == ENC_HEAD);
      assign is_tail_s[gi] = (ftype_s == ENC_TAIL);
      assign is_sing_s[gi] = (ftype_s == ENC_SING);
      assign request_s[gi] = valid_in[gi] & (is_head_s[gi] | is_sing_s[gi]) &
                             (dest_s == which_port);
    end
  endgenerate

  // New packets are only arbitrated while the output is unlocked and free.
  assign avail_s = (lock_r == {NUM_IN{1'b0}}) & ~busy_in;

  noc_rr_arbiter #(
    .N      (NUM_IN),
    .POLICY (POLICY)
  ) u_arb (
    .req   ({NUM_IN{avail_s}} & request_s),
    .prio  (prio_r),
    .grant (grant_s)
  );

  assign want_s       = (request_s | lock_r) & valid_in;
  assign accept_s     = want_s & (grant_s | lock_r) & {NUM_IN{~busy_in}};
  assign select       = grant_s | (lock_r & valid_in);
  assign nack_out     = want_s & ~accept_s;
  assign valid_out    = (|(lock_r & valid_in)) | ((|request_s) & (lock_r == {NUM_IN{1'b0}}));
  assign shift_ctl    = |grant_s;
  assign hold_timeout = hold_timeout_r;

  // Lock follows a granted head and opens once the owner's tail is accepted.
  assign lock_next_s = (grant_s & is_head_s) | (lock_r & ~(is_tail_s & accept_s));

  // Watchdog: the lock is idle when held but the owner delivered nothing.
  assign owner_acc_s = |(lock_r & accept_s);
  assign idle_s      = (|lock_r) & ~owner_acc_s;
  assign fire_s      = WD_EN & idle_s & (hold_cnt_r == CNT_LAST);

  // Next round-robin pointer: the input after the granted one.
  always_comb begin
    prio_rot_s = {NUM_IN{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      prio_rot_s[(i + 1) % NUM_IN] = grant_s[i];
    end
    if ((POLICY == POL_RR) && (|grant_s)) begin
      prio_next_s = prio_rot_s;
    end else begin
      prio_next_s = prio_r;
    end
  end

  // Idle-lock counter advances only while the lock is held and silent.
  always_comb begin
    hold_cnt_next_s = {CNT_W{1'b0}};
    if (WD_EN && idle_s && !fire_s) begin
      hold_cnt_next_s = hold_cnt_r + CNT_W'(1);
    end else begin
      hold_cnt_next_s = {CNT_W{1'b0}};
    end
  end

  // State registers; a watchdog release overrides the normal lock update.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r         <= {NUM_IN{1'b0}};
      prio_r         <= PRIO_RST;
      hold_cnt_r     <= {CNT_W{1'b0}};
      hold_timeout_r <= 1'b0;
    end else begin
      lock_r         <= fire_s ? {NUM_IN{1'b0}} : lock_next_s;
      prio_r         <= prio_next_s;
      hold_cnt_r     <= hold_cnt_next_s;
      hold_timeout_r <= fire_s;
    end
  end

endmodule

// File: tb/tb_noc_switch_allocator_param.sv
module tb_noc_switch_allocator_param;

  localparam logic [1:0] H = 2'd0, P = 2'd1, T = 2'd2, S = 2'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   which_port;
  logic [239:0] flit_in;
  logic [2:0]   valid_in;
  logic         busy_in;

  logic [2:0] sel_rr, nk_rr, sel_fx, nk_fx, sel_wd, nk_wd;
  logic       vo_rr, sh_rr, to_rr, vo_fx, sh_fx, to_fx, vo_wd, sh_wd, to_wd;
  logic [8:0] o_rr, o_fx, o_wd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign o_rr = {sel_rr, vo_rr, nk_rr, sh_rr, to_rr};
  assign o_fx = {sel_fx, vo_fx, nk_fx, sh_fx, to_fx};
  assign o_wd = {sel_wd, vo_wd, nk_wd, sh_wd, to_wd};

  noc_switch_allocator_param #(.NUM_IN(3), .FLIT_W(80), .PORT_ID_W(3), .POLICY(0), .HOLD_MAX(0)) u_rr (
    .clk(clk), .rst(rst), .which_port(which_port), .flit_in(flit_in), .valid_in(valid_in),
    .busy_in(busy_in), .select(sel_rr), .valid_out(vo_rr), .nack_out(nk_rr),
    .shift_ctl(sh_rr), .hold_timeout(to_rr));

  noc_switch_allocator_param #(.NUM_IN(3), .FLIT_W(80), .PORT_ID_W(3), .POLICY(1), .HOLD_MAX(1)) u_fx (
    .clk(clk), .rst(rst), .which_port(which_port), .flit_in(flit_in), .valid_in(valid_in),
    .busy_in(busy_in), .select(sel_fx), .valid_out(vo_fx), .nack_out(nk_fx),
    .shift_ctl(sh_fx), .hold_timeout(to_fx));

  noc_switch_allocator_param #(.NUM_IN(3), .FLIT_W(80), .PORT_ID_W(3), .POLICY(0), .HOLD_MAX(4)) u_wd (
    .clk(clk), .rst(rst), .which_port(which_port), .flit_in(flit_in), .valid_in(valid_in),
    .busy_in(busy_in), .select(sel_wd), .valid_out(vo_wd), .nack_out(nk_wd),
    .shift_ctl(sh_wd), .hold_timeout(to_wd));

  // ---------------- reference model (packet-level view) ----------------
  typedef struct packed {
    int   owner;   // input holding the output, -1 when free
    int   rr;      // index of the input with round-robin priority
    int   idle;    // consecutive silent cycles of the owner
    logic to;      // watchdog pulse visible this cycle
  } mst_t;

  localparam mst_t M_RST = '{owner: -1, rr: 0, idle: 0, to: 1'b0};

  mst_t ms_rr, ms_fx, ms_wd;

  function automatic logic [1:0] m_type(input logic [239:0] f, input int i);
    return f[i*80 +: 2];
  endfunction

  function automatic bit m_req(input logic [2:0] v, input logic [239:0] f, input int i);
    logic [2:0] d;
    d = f[i*80+2 +: 3];
    return v[i] && (m_type(f, i) == H || m_type(f, i) == S) && (d == 3'd2);
  endfunction

  function automatic int m_grant(input mst_t s, input int pol, input logic [2:0] v,
                                 input logic [239:0] f, input logic b);
    int g;
    g = -1;
    if (s.owner < 0 && !b) begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (pol == 1) ? k : (s.rr + k) % 3;
        if (g < 0 && m_req(v, f, j)) g = j;
      end
    end
    return g;
  endfunction

  function automatic logic [8:0] m_out(input mst_t s, input int pol, input logic [2:0] v,
                                       input logic [239:0] f, input logic b);
    int g;
    logic [2:0] sel, nk;
    bit any, vo;
    g = m_grant(s, pol, v, f, b);
    sel = 3'b000; nk = 3'b000; any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit own, want, acc;
      own  = (i == s.owner);
      want = v[i] && (m_req(v, f, i) || own);
      acc  = want && (i == g || own) && !b;
      sel[i] = (i == g) || (own && v[i]);
      nk[i]  = want && !acc;
      if (m_req(v, f, i)) any = 1'b1;
    end
    vo = any;
    if (s.owner >= 0) vo = v[s.owner];
    return {sel, vo, nk, (g >= 0), s.to};
  endfunction

  function automatic mst_t m_next(input mst_t s, input int pol, input int hmax, input logic [2:0] v,
                                  input logic [239:0] f, input logic b);
    mst_t n;
    int g;
    bit oacc;
    g = m_grant(s, pol, v, f, b);
    n = s;
    n.to = 1'b0;
    oacc = 1'b0;
    if (s.owner >= 0) oacc = v[s.owner] && !b;
    if (g >= 0) begin
      n.rr = (g + 1) % 3;
      if (m_type(f, g) == H) n.owner = g;
    end else if (oacc && m_type(f, s.owner) == T) begin
      n.owner = -1;
    end
    if (hmax > 0) begin
      if (s.owner < 0 || oacc) n.idle = 0;
      else if (s.idle == hmax - 1) begin
        n.owner = -1; n.idle = 0; n.to = 1'b1;
      end else n.idle = s.idle + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ms_rr <= M_RST; ms_fx <= M_RST; ms_wd <= M_RST;
    end else begin
      ms_rr <= m_next(ms_rr, 0, 0, valid_in, flit_in, busy_in);
      ms_fx <= m_next(ms_fx, 1, 1, valid_in, flit_in, busy_in);
      ms_wd <= m_next(ms_wd, 0, 4, valid_in, flit_in, busy_in);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [79:0] mk(input logic [1:0] t, input logic [2:0] d);
    logic [79:0] x;
    x = {16'($urandom()), 32'($urandom()), 32'($urandom())};
    x[4:0] = {d, t};
    return x;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [5:0] ty, input logic b);
    valid_in = v;
    flit_in  = {mk(ty[5:4], 3'd2), mk(ty[3:2], 3'd2), mk(ty[1:0], 3'd2)};
    busy_in  = b;
  endtask

  task automatic do_reset();
    valid_in = 3'b000; busy_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    valid_in = 3'b000;
    @(negedge clk);
    n_checks++;
    if (o_rr !== 9'b0) $display("FAIL reset_rr got=%b exp=%b", o_rr, 9'b0); else n_pass++;
    n_checks++;
    if (o_fx !== 9'b0) $display("FAIL reset_fx got=%b exp=%b", o_fx, 9'b0); else n_pass++;
    n_checks++;
    if (o_wd !== 9'b0) $display("FAIL reset_wd got=%b exp=%b", o_wd, 9'b0); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_rr_fairness();
    logic [2:0] g;
    logic [8:0] e;
    do_reset();
    g = 3'b001;
    for (int k = 0; k < 4; k++) begin
      drive(3'b111, {S, S, S}, 1'b0);
      e = {g, 1'b1, ~g, 1'b1, 1'b0};
      @(negedge clk);
      n_checks++;
      if (o_rr !== e) $display("FAIL rr_fair[%0d] got=%b exp=%b", k, o_rr, e); else n_pass++;
      @(posedge clk); #1;
      g = {g[1:0], g[2]};
    end
  endtask

  task automatic test_packet_lock();
    logic [2:0] v_t [7] = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b001, 3'b001, 3'b010};
    logic [5:0] y_t [7] = '{{P,P,S}, {P,H,H}, {P,P,H}, {P,T,H}, {P,P,H}, {P,P,T}, {P,P,P}};
    logic [8:0] e_t [7] = '{9'b001_1_000_1_0, 9'b010_1_001_1_0, 9'b010_1_001_0_0,
                            9'b010_1_001_0_0, 9'b001_1_000_1_0, 9'b001_1_000_0_0,
                            9'b000_0_000_0_0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(v_t[k], y_t[k], 1'b0);
      @(negedge clk);
      n_checks++;
      if (o_rr !== e_t[k]) $display("FAIL pkt_lock[%0d] got=%b exp=%b", k, o_rr, e_t[k]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy();
    logic [2:0] v_t [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b000};
    logic [5:0] y_t [6] = '{{H,P,P}, {T,P,P}, {T,P,P}, {P,P,S}, {P,S,P}, {P,P,P}};
    logic       b_t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] e_t [6] = '{9'b100_1_000_1_0, 9'b100_1_100_0_0, 9'b100_1_000_0_0,
                            9'b001_1_000_1_0, 9'b000_1_010_0_0, 9'b000_0_000_0_0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(v_t[k], y_t[k], b_t[k]);
      @(negedge clk);
      n_checks++;
      if (o_rr !== e_t[k]) $display("FAIL busy[%0d] got=%b exp=%b", k, o_rr, e_t[k]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fixed_priority();
    logic [2:0] v_t [8] = '{3'b110, 3'b111, 3'b110, 3'b001, 3'b000, 3'b010, 3'b000, 3'b000};
    logic [5:0] y_t [8] = '{{S,S,S}, {S,S,S}, {S,S,S}, {P,P,H}, {P,P,P}, {P,H,P}, {P,P,P}, {P,P,P}};
    logic [8:0] e_t [8] = '{9'b010_1_100_1_0, 9'b001_1_110_1_0, 9'b010_1_100_1_0,
                            9'b001_1_000_1_0, 9'b000_0_000_0_0, 9'b010_1_000_1_1,
                            9'b000_0_000_0_0, 9'b000_0_000_0_1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(v_t[k], y_t[k], 1'b0);
      @(negedge clk);
      n_checks++;
      if (o_fx !== e_t[k]) $display("FAIL fixed[%0d] got=%b exp=%b", k, o_fx, e_t[k]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    logic [2:0] v_t [7] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000};
    logic [5:0] y_t [7] = '{{P,P,H}, {P,P,P}, {P,P,P}, {P,P,P}, {P,H,P}, {P,H,P}, {P,P,P}};
    logic [8:0] e_t [7] = '{9'b001_1_000_1_0, 9'b000_0_000_0_0, 9'b000_0_000_0_0,
                            9'b000_0_000_0_0, 9'b000_0_010_0_0, 9'b010_1_000_1_1,
                            9'b000_0_000_0_0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(v_t[k], y_t[k], 1'b0);
      @(negedge clk);
      n_checks++;
      if (o_wd !== e_t[k]) $display("FAIL watchdog[%0d] got=%b exp=%b", k, o_wd, e_t[k]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [2:0] v_t [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
    logic [5:0] y_t [6] = '{{P,P,S}, {P,H,P}, {P,P,P}, {P,P,P}, {P,P,P}, {S,S,S}};
    logic       r_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0] e_t [6] = '{9'b001_1_000_1_0, 9'b010_1_000_1_0, 9'b010_1_000_0_0,
                            9'b010_1_000_0_0, 9'b000_0_000_0_0, 9'b001_1_110_1_0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(v_t[k], y_t[k], 1'b0);
      rst = r_t[k];
      @(negedge clk);
      n_checks++;
      if (o_rr !== e_t[k]) $display("FAIL rst_mid[%0d] got=%b exp=%b", k, o_rr, e_t[k]); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(99) == 0);
      valid_in = 3'($urandom_range(7));
      busy_in  = ($urandom_range(3) == 0);
      for (int i = 0; i < 3; i++) begin
        logic [2:0] d;
        d = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd2;
        flit_in[i*80 +: 80] = mk(2'($urandom_range(3)), d);
      end
      @(negedge clk);
      e = m_out(ms_rr, 0, valid_in, flit_in, busy_in);
      n_checks++;
      if (o_rr !== e) $display("FAIL rand_rr[%0d] got=%b exp=%b", k, o_rr, e); else n_pass++;
      e = m_out(ms_fx, 1, valid_in, flit_in, busy_in);
      n_checks++;
      if (o_fx !== e) $display("FAIL rand_fx[%0d] got=%b exp=%b", k, o_fx, e); else n_pass++;
      e = m_out(ms_wd, 0, valid_in, flit_in, busy_in);
      n_checks++;
      if (o_wd !== e) $display("FAIL rand_wd[%0d] got=%b exp=%b", k, o_wd, e); else n_pass++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    which_port = 3'd2;
    flit_in    = 240'b0;
    valid_in   = 3'b000;
    busy_in    = 1'b0;
    test_reset();
    test_rr_fairness();
    test_packet_lock();
    test_busy();
    test_fixed_priority();
    test_watchdog();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
